// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared pipeline definitions for the fetch redirect controller.
//   fetch_state_e  : fetch FSM state encoding (BOOT=0, RUN=1, WAIT_MEM=2, PENDING=3)
//   redirect_src_e : which source won the redirect priority selection
//   PC_W / CNT_W   : program-counter width and mispredict counter width
package fetch_redirect_ctrl_pkg;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_PENDING  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EX   = 2'd1,
    SRC_ID   = 2'd2,
    SRC_BTB  = 2'd3
  } redirect_src_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect control bus.
//   master : pipeline side (drives memory/hazard/branch inputs, receives PC/pipe controls)
//   slave  : fetch_redirect_ctrl (consumes those inputs, drives the controls)
interface fetch_redirect_ctrl_if;
  import fetch_redirect_ctrl_pkg::*;

  logic             imem_ready;
  logic             load_use;
  logic             ex_mispredict;
  logic [PC_W-1:0]  ex_correct_pc;
  logic             id_jump;
  logic [PC_W-1:0]  id_jump_target;
  logic             btb_hit;
  logic [PC_W-1:0]  btb_target;
  logic             pc_write;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output imem_ready, load_use, ex_mispredict, ex_correct_pc,
           id_jump, id_jump_target, btb_hit, btb_target,
    input  pc_write, redirect_valid, redirect_pc, ifid_write,
           ifid_flush, idex_flush, state, mispredict_count
  );

  modport slave (
    input  imem_ready, load_use, ex_mispredict, ex_correct_pc,
           id_jump, id_jump_target, btb_hit, btb_target,
    output pc_write, redirect_valid, redirect_pc, ifid_write,
           ifid_flush, idex_flush, state, mispredict_count
  );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_prio_mux.sv
// redirect_prio_mux: combinational redirect source selection.
//   Priority ex > id > btb; nothing valid means sequential fetch.
//   Inputs : per-source valid + target.
//   Outputs: sel_valid, sel_target, sel_src (winning source).
module redirect_prio_mux
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_target,
  input  logic            id_valid,
  input  logic [PC_W-1:0] id_target,
  input  logic            btb_valid,
  input  logic [PC_W-1:0] btb_target,
  output logic            sel_valid,
  output logic [PC_W-1:0] sel_target,
  output redirect_src_e   sel_src
);

  always_comb begin
    sel_valid  = 1'b0;
    sel_target = '0;
    sel_src    = SRC_NONE;
    if (ex_valid) begin
      sel_valid  = 1'b1;
      sel_target = ex_target;
      sel_src    = SRC_EX;
    end else if (id_valid) begin
      sel_valid  = 1'b1;
      sel_target = id_target;
      sel_src    = SRC_ID;
    end else if (btb_valid) begin
      sel_valid  = 1'b1;
      sel_target = btb_target;
      sel_src    = SRC_BTB;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: next-PC / pipeline-register control for the fetch stage.
//   Clk, Reset : rising-edge clock, synchronous active-high reset
//   bus (slave): imem_ready, load_use, ex_mispredict/ex_correct_pc,
//                id_jump/id_jump_target, btb_hit/btb_target in;
//                pc_write, redirect_valid/redirect_pc, ifid_write, ifid_flush,
//                idex_flush, state, mispredict_count out.
// A redirect chosen while memory is not ready is parked in a pending register
// and applied on the first ready cycle.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset,
  fetch_redirect_ctrl_if.slave  bus
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;

  logic            sel_valid;
  logic [PC_W-1:0] sel_target;
  redirect_src_e   sel_src;
  logic [PC_W-1:0] pend_target;

  logic            pc_write, redirect_valid, ifid_flush, idex_flush;
  logic [PC_W-1:0] redirect_pc;

  // A load-use stall suppresses the ID jump and the BTB prediction, but not EX.
  redirect_prio_mux u_prio (
    .ex_valid   (bus.ex_mispredict),
    .ex_target  (bus.ex_correct_pc),
    .id_valid   (bus.id_jump & ~bus.load_use),
    .id_target  (bus.id_jump_target),
    .btb_valid  (bus.btb_hit & ~bus.load_use),
    .btb_target (bus.btb_target),
    .sel_valid  (sel_valid),
    .sel_target (sel_target),
    .sel_src    (sel_src)
  );

  // Only an EX mispredict may replace a parked target.
  assign pend_target = bus.ex_mispredict ? bus.ex_correct_pc : pend_q;

  always_comb begin
    pc_write       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    state_d        = state_q;
    pend_d         = pend_q;
    case (state_q)
      ST_BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = ST_RUN;
      end
      // WAIT_MEM shares the RUN rules: it only differs by having no accepted
      // fetch yet, so a redirect arriving while waiting is parked, not lost.
      ST_RUN, ST_WAIT_MEM: begin
        ifid_flush = (sel_src == SRC_EX) || (sel_src == SRC_ID);
        idex_flush = (sel_src == SRC_EX) || bus.load_use;
        if (sel_valid) begin
          if (bus.imem_ready) begin
            pc_write       = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = sel_target;
            state_d        = ST_RUN;
          end else begin
            pend_d  = sel_target;
            state_d = ST_PENDING;
          end
        end else begin
          pc_write = bus.imem_ready & ~bus.load_use;
          state_d  = bus.imem_ready ? ST_RUN : ST_WAIT_MEM;
        end
      end
      ST_PENDING: begin
        // The slot in IF is wrong-path until the parked redirect is applied.
        ifid_flush = 1'b1;
        idex_flush = bus.ex_mispredict;
        if (bus.imem_ready) begin
          pc_write       = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = pend_target;
          state_d        = ST_RUN;
        end else begin
          pend_d = pend_target;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (Reset) begin
      pc_write       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      ifid_flush     = 1'b1;
      idex_flush     = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_BOOT;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (bus.ex_mispredict && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc_write         = pc_write;
  assign bus.redirect_valid   = redirect_valid;
  assign bus.redirect_pc      = redirect_pc;
  assign bus.ifid_write       = pc_write;
  assign bus.ifid_flush       = ifid_flush;
  assign bus.idex_flush       = idex_flush;
  assign bus.state            = state_q;
  assign bus.mispredict_count = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  fetch_redirect_ctrl_if bus ();

  fetch_redirect_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic lu, input logic mp, input logic [31:0] mpc,
                       input logic jp, input logic [31:0] jpc, input logic bh, input logic [31:0] bt);
    bus.imem_ready     = rdy;
    bus.load_use       = lu;
    bus.ex_mispredict  = mp;
    bus.ex_correct_pc  = mpc;
    bus.id_jump        = jp;
    bus.id_jump_target = jpc;
    bus.btb_hit        = bh;
    bus.btb_target     = bt;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Leaves the DUT in BOOT with Reset low, just after a clock edge.
  task automatic do_reset();
    idle();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle();
    bus.imem_ready = 1'b0;
    #1;
    total++; if (bus.state !== 2'd3 || bus.mispredict_count !== 16'd1) begin
      bad++; $display("FAIL rst_pre_pending state=%0d cnt=%0d exp state=3 cnt=1", bus.state, bus.mispredict_count);
    end
    Reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h5678, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if ({bus.pc_write, bus.redirect_valid, bus.ifid_flush, bus.idex_flush} !== 4'b0011 || bus.redirect_pc !== 32'h0) begin
      bad++; $display("FAIL rst_outputs pw/rv/iff/idf=%b rpc=%h exp 0011 rpc=0", {bus.pc_write, bus.redirect_valid, bus.ifid_flush, bus.idex_flush}, bus.redirect_pc);
    end
    tick();
    total++; if (bus.state !== 2'd0 || bus.mispredict_count !== 16'd0) begin
      bad++; $display("FAIL rst_state state=%0d cnt=%0d exp 0/0", bus.state, bus.mispredict_count);
    end
    Reset = 1'b0;
    idle();
    tick();
    #1;
    total++; if (bus.state !== 2'd1 || bus.redirect_valid !== 1'b0 || bus.pc_write !== 1'b1) begin
      bad++; $display("FAIL rst_pending_discard state=%0d rv=%b pw=%b exp 1/0/1", bus.state, bus.redirect_valid, bus.pc_write);
    end
  endtask

  task automatic test_boot();
    do_reset();
    #1;
    total++; if (bus.state !== 2'd0 || bus.pc_write !== 1'b0 || bus.ifid_write !== 1'b0 || bus.ifid_flush !== 1'b1) begin
      bad++; $display("FAIL boot_cycle0 state=%0d pw=%b iw=%b iff=%b exp 0/0/0/1", bus.state, bus.pc_write, bus.ifid_write, bus.ifid_flush);
    end
    tick();
    total++; if (bus.state !== 2'd1 || bus.pc_write !== 1'b1 || bus.redirect_valid !== 1'b0) begin
      bad++; $display("FAIL boot_cycle1 state=%0d pw=%b rv=%b exp 1/1/0", bus.state, bus.pc_write, bus.redirect_valid);
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100 || bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1 || bus.pc_write !== 1'b1) begin
      bad++; $display("FAIL prio_ex rv=%b rpc=%h iff=%b idf=%b pw=%b exp 1/100/1/1/1", bus.redirect_valid, bus.redirect_pc, bus.ifid_flush, bus.idex_flush, bus.pc_write);
    end
    tick();
    total++; if (bus.mispredict_count !== 16'd1) begin
      bad++; $display("FAIL prio_count cnt=%0d exp 1", bus.mispredict_count);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    total++; if (bus.redirect_pc !== 32'h200 || bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b0 || bus.redirect_valid !== 1'b1) begin
      bad++; $display("FAIL prio_id rpc=%h iff=%b idf=%b rv=%b exp 200/1/0/1", bus.redirect_pc, bus.ifid_flush, bus.idex_flush, bus.redirect_valid);
    end
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    total++; if (bus.redirect_pc !== 32'h300 || bus.ifid_flush !== 1'b0 || bus.idex_flush !== 1'b0 || bus.ifid_write !== 1'b1) begin
      bad++; $display("FAIL prio_btb rpc=%h iff=%b idf=%b iw=%b exp 300/0/0/1", bus.redirect_pc, bus.ifid_flush, bus.idex_flush, bus.ifid_write);
    end
    tick();
    idle();
    #1;
    total++; if (bus.redirect_valid !== 1'b0 || bus.pc_write !== 1'b1 || bus.ifid_write !== 1'b1) begin
      bad++; $display("FAIL prio_seq rv=%b pw=%b iw=%b exp 0/1/1", bus.redirect_valid, bus.pc_write, bus.ifid_write);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h300);
    #1;
    total++; if ({bus.pc_write, bus.ifid_write, bus.idex_flush, bus.redirect_valid} !== 4'b0010) begin
      bad++; $display("FAIL lu_stall pw/iw/idf/rv=%b exp 0010", {bus.pc_write, bus.ifid_write, bus.idex_flush, bus.redirect_valid});
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    total++; if (bus.pc_write !== 1'b1 || bus.redirect_pc !== 32'h500 || bus.ifid_flush !== 1'b1 || bus.idex_flush !== 1'b1) begin
      bad++; $display("FAIL lu_mp_override pw=%b rpc=%h iff=%b idf=%b exp 1/500/1/1", bus.pc_write, bus.redirect_pc, bus.ifid_flush, bus.idex_flush);
    end
    tick();
  endtask

  task automatic test_pending();
    do_reset();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    total++; if (bus.pc_write !== 1'b0 || bus.ifid_flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin
      bad++; $display("FAIL pend_latch pw=%b iff=%b rv=%b exp 0/1/0", bus.pc_write, bus.ifid_flush, bus.redirect_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h999, 1'b1, 32'h777);
      #1;
      total++; if (bus.state !== 2'd3 || bus.pc_write !== 1'b0) begin
        bad++; $display("FAIL pend_hold%0d state=%0d pw=%b exp 3/0", i, bus.state, bus.pc_write);
      end
      tick();
    end
    idle();
    #1;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h40 || bus.pc_write !== 1'b1) begin
      bad++; $display("FAIL pend_release rv=%b rpc=%h pw=%b exp 1/40/1", bus.redirect_valid, bus.redirect_pc, bus.pc_write);
    end
    tick();
    total++; if (bus.state !== 2'd1) begin
      bad++; $display("FAIL pend_to_run state=%0d exp 1", bus.state);
    end
  endtask

  task automatic test_pending_overwrite();
    do_reset();
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    total++; if (bus.state !== 2'd3 || bus.idex_flush !== 1'b1) begin
      bad++; $display("FAIL ovw_flush state=%0d idf=%b exp 3/1", bus.state, bus.idex_flush);
    end
    tick();
    idle();
    bus.imem_ready = 1'b0;
    tick();
    idle();
    #1;
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h80) begin
      bad++; $display("FAIL ovw_release rv=%b rpc=%h exp 1/80", bus.redirect_valid, bus.redirect_pc);
    end
    tick();
  endtask

  // Reference model: mode numbers follow the published encoding; the redirect
  // choice is the head of a candidate list built in priority order.
  task automatic test_random(input int unsigned n);
    int m_state, e_next;
    logic [31:0] m_pend, e_pend, e_pc, tgt, mpc, jpc, bt;
    int unsigned m_cnt;
    logic rdy, lu, mp, jp, bh, rst, e_pw, e_rv, e_iff, e_idf;
    logic [31:0] cands[$];
    do_reset();
    m_state = 0; m_pend = '0; m_cnt = 0;
    for (int unsigned i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      lu  = ($urandom_range(0, 9) < 2);
      mp  = ($urandom_range(0, 19) < 3);
      jp  = ($urandom_range(0, 9) < 2);
      bh  = ($urandom_range(0, 3) == 0);
      mpc = $urandom & 32'hFFFF_FFFC;
      jpc = $urandom & 32'hFFFF_FFFC;
      bt  = $urandom & 32'hFFFF_FFFC;
      drive(rdy, lu, mp, mpc, jp, jpc, bh, bt);
      Reset = rst;
      #1;
      e_pw = 0; e_rv = 0; e_pc = '0; e_iff = 0; e_idf = 0; e_next = m_state; e_pend = m_pend;
      if (rst) begin
        e_iff = 1; e_idf = 1; e_next = 0; e_pend = '0;
      end else if (m_state == 0) begin
        e_iff = 1; e_idf = 1; e_next = 1;
      end else if (m_state == 3) begin
        tgt = mp ? mpc : m_pend;
        e_iff = 1; e_idf = mp;
        if (rdy) begin e_pw = 1; e_rv = 1; e_pc = tgt; e_next = 1; end
        else e_pend = tgt;
      end else begin
        cands.delete();
        if (mp) cands.push_back(mpc);
        if (jp && !lu) cands.push_back(jpc);
        if (bh && !lu) cands.push_back(bt);
        e_iff = mp || (jp && !lu);
        e_idf = mp || lu;
        if (cands.size() > 0) begin
          if (rdy) begin e_pw = 1; e_rv = 1; e_pc = cands[0]; e_next = 1; end
          else begin e_pend = cands[0]; e_next = 3; end
        end else begin
          e_pw = rdy && !lu;
          e_next = rdy ? 1 : 2;
        end
      end
      total++; if ({bus.state, bus.pc_write, bus.redirect_valid, bus.ifid_flush, bus.idex_flush} !== {2'(m_state), e_pw, e_rv, e_iff, e_idf}) begin
        bad++; $display("FAIL rnd_ctrl cyc=%0d st/pw/rv/iff/idf=%b exp %b", i, {bus.state, bus.pc_write, bus.redirect_valid, bus.ifid_flush, bus.idex_flush}, {2'(m_state), e_pw, e_rv, e_iff, e_idf});
      end
      if (e_rv || rst) begin
        total++; if (bus.redirect_pc !== e_pc) begin
          bad++; $display("FAIL rnd_pc cyc=%0d rpc=%h exp %h", i, bus.redirect_pc, e_pc);
        end
      end
      if (!e_iff) begin
        total++; if (bus.ifid_write !== e_pw) begin
          bad++; $display("FAIL rnd_ifid_write cyc=%0d iw=%b exp %b", i, bus.ifid_write, e_pw);
        end
      end
      total++; if (bus.mispredict_count !== 16'(m_cnt)) begin
        bad++; $display("FAIL rnd_count cyc=%0d cnt=%0d exp %0d", i, bus.mispredict_count, m_cnt);
      end
      @(posedge Clk);
      #1;
      m_state = e_next;
      m_pend  = e_pend;
      if (rst) m_cnt = 0;
      else if (mp && m_cnt < 65535) m_cnt++;
    end
    Reset = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    tick();
    drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int k = 1; k <= 70000; k++) begin
      tick();
      if (k == 65534) begin
        total++; if (bus.mispredict_count !== 16'hFFFE) begin
          bad++; $display("FAIL sat_below cnt=%h exp fffe", bus.mispredict_count);
        end
      end
      if (k == 65535) begin
        total++; if (bus.mispredict_count !== 16'hFFFF) begin
          bad++; $display("FAIL sat_reach cnt=%h exp ffff", bus.mispredict_count);
        end
      end
    end
    total++; if (bus.mispredict_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_hold cnt=%h exp ffff", bus.mispredict_count);
    end
    Reset = 1'b1;
    tick();
    total++; if (bus.mispredict_count !== 16'h0) begin
      bad++; $display("FAIL sat_reset cnt=%h exp 0", bus.mispredict_count);
    end
    Reset = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_boot();
    test_priority();
    test_load_use();
    test_pending();
    test_pending_overwrite();
    test_random(3000);
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 SHALL have ports: Clk  input  1  rising-edge clock.
REQ-002 SHALL have ports: Reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: imem_ready  input  1  instruction memory accepts a fetch this cycle.
REQ-004 SHALL have ports: load_use  input  1  hazard unit stall request (load-use).
REQ-005 SHALL have ports: ex_mispredict  input  1  EX branch outcome differs from prediction.
REQ-006 SHALL have ports: ex_correct_pc  input  32  correct PC for the EX mispredict.
REQ-007 SHALL have ports: id_jump  input  1  jump decoded in ID.
REQ-008 SHALL have ports: id_jump_target  input  32  target of the ID jump.
REQ-009 SHALL have ports: btb_hit  input  1  BTB predicts taken for the current fetch PC.
REQ-010 SHALL have ports: btb_target  input  32  BTB predicted address.
REQ-011 SHALL have ports: pc_write  output  1  PC register load enable.
REQ-012 SHALL have ports: redirect_valid  output  1  PC loads redirect_pc instead of pc+4.
REQ-013 SHALL have ports: redirect_pc  output  32  next PC when redirect_valid=1.
REQ-014 SHALL have ports: ifid_write  output  1  IF/ID register load enable.
REQ-015 SHALL have ports: ifid_flush  output  1  IF/ID becomes bubble.
REQ-016 SHALL have ports: idex_flush  output  1  ID/EX becomes bubble.
REQ-017 SHALL have ports: state  output  2  current FSM state encoding.
REQ-018 SHALL have ports: mispredict_count  output  16  saturating EX mispredict count.

Function
REQ-019 SHALL implement FSM states BOOT, RUN, WAIT_MEM, PENDING; all outputs combinational from state, pending register and inputs.
REQ-020 BOOT: pc_write=0, ifid_write=0, ifid_flush=1; SHALL move to RUN after exactly one cycle.
REQ-021 RUN: redirect source priority SHALL be ex_mispredict > id_jump > btb_hit > sequential (redirect_valid=0).
REQ-022 RUN, imem_ready=1: pc_write=1 and the chosen redirect SHALL be applied the same cycle (zero-latency select).
REQ-023 ex_mispredict SHALL assert ifid_flush and idex_flush and override load_use in the same cycle.
REQ-024 id_jump (no mispredict) SHALL assert ifid_flush only; id_jump SHALL be ignored while load_use=1.
REQ-025 load_use (no mispredict): pc_write=0, ifid_write=0, idex_flush=1; btb_hit SHALL be ignored that cycle.
REQ-026 RUN, imem_ready=0, no redirect: pc_write=0, ifid_write=0; SHALL go to WAIT_MEM.
REQ-027 RUN, imem_ready=0 with redirect: SHALL latch redirect target in pending register, assert flushes per REQ-023/024, go to PENDING.
REQ-028 WAIT_MEM: hold PC and IF/ID; SHALL return to RUN the first cycle imem_ready=1 and evaluate RUN rules that cycle.
REQ-029 PENDING: pc_write=0 until imem_ready=1; then redirect_valid=1, redirect_pc=pending, pc_write=1, go to RUN.
REQ-030 PENDING: a new ex_mispredict SHALL overwrite the pending target; id_jump/btb_hit SHALL not.
REQ-031 mispredict_count SHALL increment once per cycle with ex_mispredict=1 and saturate at 16'hFFFF.
REQ-032 ifid_write SHALL equal pc_write except when ifid_flush=1 (flush dominates, write value irrelevant).

Reset
REQ-033 Reset=1 at a clock edge SHALL force state=BOOT, pending register=0, mispredict_count=0, regardless of FSM state.
REQ-034 While Reset=1 outputs SHALL be BOOT values: pc_write=0, redirect_valid=0, redirect_pc=0, ifid_flush=1, idex_flush=1.
REQ-035 Reset during PENDING SHALL discard the pending redirect.

Structure
REQ-036 State encoding (BOOT=0, RUN=1, WAIT_MEM=2, PENDING=3) and counter width SHALL live in the shared pipeline package.
REQ-037 Priority selection SHALL be one sub-module, redirect_prio_mux (combinational, returns valid+target+source).

Verification
REQ-038 Reset release -> cycle 0 BOOT pc_write=0; cycle 1 RUN pc_write=1, redirect_valid=0.
REQ-039 RUN, ex_mispredict=1 ex_correct_pc=0x100, id_jump=1 target 0x200, btb_hit=1 -> redirect_pc=0x100, both flushes=1, count=1.
REQ-040 load_use=1, id_jump=1 -> pc_write=0, ifid_write=0, idex_flush=1, redirect_valid=0.
REQ-041 id_jump=1 target 0x40, imem_ready=0 for 3 cycles -> PENDING 3 cycles pc_write=0; fourth cycle redirect_pc=0x40, pc_write=1, RUN.
REQ-042 PENDING 0x40, ex_mispredict target 0x80 -> later release applies 0x80.
REQ-043 70000 consecutive mispredict cycles -> mispredict_count holds 0xFFFF; Reset -> 0.
